// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types and constants for the UART input-port receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 434;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_byte
//  Brief    : 8N1 byte receiver: rx synchronizer, baud counter and byte FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_ferr
);

    localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [2:0]       C_BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic                      r_sync1;
    logic                      r_sync2;
    uart_rx_state_t            r_state;
    uart_rx_state_t            w_state_nx;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nx;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_bit_idx_nx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_bit_idx <= w_bit_idx_nx;
            r_shift   <= w_shift_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt + 1'b1;
        w_bit_idx_nx = r_bit_idx;
        w_shift_nx   = r_shift;
        byte_valid   = 1'b0;
        byte_ferr    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (!r_sync2) begin
                    w_state_nx = START;
                end
            end
            START: begin
                // Mid-start-bit re-check; a high line here was only a glitch.
                if (r_cnt == C_CNT_HALF) begin
                    w_cnt_nx     = '0;
                    w_bit_idx_nx = '0;
                    w_state_nx   = r_sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nx     = '0;
                    w_shift_nx   = {r_sync2, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_idx_nx = r_bit_idx + 3'd1;
                    if (r_bit_idx == C_BIT_LAST) begin
                        w_state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                    byte_valid = r_sync2;
                    byte_ferr  = !r_sync2;
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = IDLE;
            end
        endcase
    end

    assign byte_data = r_shift;

endmodule
`default_nettype wire

// File: rtl/uart_inport_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_inport_rx
//  Brief    : Packs four UART bytes into a 32-bit input-port word with a
//             ready/ack handshake and sticky frame-error / overrun flags.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_inport_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        ack,
    input  logic        err_clr,
    output logic [31:0] in_port_data,
    output logic        data_ready,
    output logic        frame_err,
    output logic        overrun
);

    logic [7:0]  w_byte_data;
    logic        w_byte_valid;
    logic        w_byte_ferr;
    logic        w_word_done;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_stage;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (w_byte_data),
        .byte_valid (w_byte_valid),
        .byte_ferr  (w_byte_ferr)
    );

    assign w_word_done = w_byte_valid && (r_byte_idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_idx   <= '0;
            r_stage      <= '0;
            in_port_data <= '0;
            data_ready   <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // A bad stop bit throws away whatever partial word was staged.
            if (w_byte_ferr) begin
                r_byte_idx <= '0;
            end else if (w_byte_valid) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_stage[7:0]   <= w_byte_data;
                    2'd1:    r_stage[15:8]  <= w_byte_data;
                    2'd2:    r_stage[23:16] <= w_byte_data;
                    default: r_stage        <= r_stage;
                endcase
            end

            if (w_word_done) begin
                in_port_data <= {w_byte_data, r_stage};
            end

            if (w_word_done) begin
                data_ready <= 1'b1;
            end else if (ack) begin
                data_ready <= 1'b0;
            end

            // Set events take priority over a coincident clear.
            if (w_word_done && data_ready && !ack) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end

            if (w_byte_ferr) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_inport_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_inport_rx
//  Brief    : Directed and randomized frame stimulus against a word-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_inport_rx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        ack;
    logic        err_clr;
    logic [31:0] in_port_data;
    logic        data_ready;
    logic        frame_err;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_word;
    logic        m_ready;
    logic        m_ferr;
    logic        m_ovr;
    logic [7:0]  m_bytes[$];

    uart_inport_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .ack          (ack),
        .err_clr      (err_clr),
        .in_port_data (in_port_data),
        .data_ready   (data_ready),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".data"},    in_port_data,       m_word);
        check_eq({tag, ".ready"},   32'(data_ready),    32'(m_ready));
        check_eq({tag, ".ferr"},    32'(frame_err),     32'(m_ferr));
        check_eq({tag, ".overrun"}, 32'(overrun),       32'(m_ovr));
    endtask

    task automatic model_reset();
        m_word  = '0;
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        m_bytes.delete();
    endtask

    // One received frame; ack/clr flags mean "asserted in the stop-sample cycle".
    task automatic model_frame(input logic [7:0] b, input bit ok, input bit ack_same, input bit clr_same);
        if (clr_same) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        if (!ok) begin
            m_bytes.delete();
            m_ferr = 1'b1;
            if (ack_same) m_ready = 1'b0;
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                if (m_ready && !ack_same) m_ovr = 1'b1;
                m_word  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                m_ready = 1'b1;
                m_bytes.delete();
            end else if (ack_same) begin
                m_ready = 1'b0;
            end
        end
    endtask

    // Called at a falling edge; the stop bit is sampled at the 156th rising edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_same, input bit clr_same);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB - 5) @(negedge clk);
        ack     = ack_same;
        err_clr = clr_same;
        @(negedge clk);
        ack     = 1'b0;
        err_clr = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (24) @(negedge clk);
        model_frame(b, stop_ok, ack_same, clr_same);
    endtask

    task automatic send_word(input logic [31:0] w, input bit ack_last);
        for (int i = 0; i < 4; i++) begin
            send_frame(w[8*i +: 8], 1'b1, (i == 3) && ack_last, 1'b0);
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        @(negedge clk);
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        ack     = 1'b0;
        err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Basic word and ack
        send_word(32'h12345678, 1'b0);
        check_outputs("word1");
        pulse_ack();
        check_outputs("word1_ack");

        // Start-bit glitch is ignored
        glitch();
        check_outputs("glitch");
        send_word(32'hCAFEF00D, 1'b0);
        check_outputs("after_glitch");
        pulse_ack();

        // Framing error discards the partial word
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        check_outputs("ferr");
        send_word(32'hDEADBEEF, 1'b0);
        check_outputs("ferr_word");
        pulse_clr();
        check_outputs("ferr_clr");
        pulse_ack();

        // Overrun, then completion with a same-cycle ack
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000002, 1'b0);
        check_outputs("overrun");
        pulse_clr();
        send_word(32'h00000003, 1'b0);
        send_word(32'h00000004, 1'b1);
        check_outputs("ack_same_cycle");

        // Set event coinciding with err_clr leaves the flag set
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check_outputs("ferr_vs_clr");

        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0: glitch();
                1: send_frame(8'($urandom), 1'b0, 1'b0, $urandom_range(0, 1) == 1);
                2, 3: pulse_ack();
                4: pulse_clr();
                default: send_frame(8'($urandom), 1'b1, $urandom_range(0, 3) == 0,
                                    $urandom_range(0, 5) == 0);
            endcase
            check_outputs("rnd");
        end

        // Reset in the middle of data bit 3 of the second byte
        send_word(32'hA5C3963C, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_reset");
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send_word(32'hDDCCBBAA, 1'b0);
        check_outputs("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
